// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: repeat FSM state encoding
// and the helper used to size the per-channel counters.
package btn_pkg;

   // Auto-repeat state per channel; encoding is fixed so debug probes and
   // checkers can decode the raw two-bit value.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_e;

   // Bits needed to hold values 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One conditioned button: 2-flop synchroniser, stability-counter debounce,
// registered edge pulses and an auto-repeat FSM feeding the press output.
//
// Handshake note: there is no valid/ready pair here. Every output is a
// registered level or one-cycle pulse, valid on every clock after reset.
module btn_channel
   import btn_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int REPEAT_DELAY  = 64,
   parameter int REPEAT_RATE   = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic rpt_en,
   output logic level,
   output logic rise,
   output logic fall,
   output logic press
);

   localparam int SW   = cnt_width(STABLE_CYCLES);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = cnt_width(RMAX);

   // Last count value before the debounced level is allowed to flip.
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   // Counter values on which the first and the following repeat pulses fire.
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST   = RW'(REPEAT_RATE - 1);

   logic            meta;
   logic            sync;
   logic [SW-1:0]   stab_cnt;
   logic [RW-1:0]   rpt_cnt;
   rpt_state_e      state;

   logic            differ;
   logic            settle;
   logic            went_high;
   logic            went_low;
   logic            rpt_fire;

   // Two-stage synchroniser; only the second stage is used downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
      end
   end

   // Decode the debounce decision and the repeat pulse for this clock.
   always_comb begin
      differ    = sync ^ level;
      settle    = differ && (stab_cnt == STABLE_LAST);
      went_high = settle && !level;
      went_low  = settle && level;
      rpt_fire  = 1'b0;
      if (rpt_en && !went_low) begin
         if ((state == DELAY) && (rpt_cnt == DELAY_LAST)) begin
            rpt_fire = 1'b1;
         end else if ((state == REPEAT) && (rpt_cnt == RATE_LAST)) begin
            rpt_fire = 1'b1;
         end
      end
   end

   // Debounce: count consecutive clocks of disagreement, flip level on the
   // STABLE_CYCLES-th one; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stab_cnt <= '0;
         level    <= 1'b0;
      end else if (!differ) begin
         stab_cnt <= '0;
      end else if (settle) begin
         stab_cnt <= '0;
         level    <= ~level;
      end else begin
         stab_cnt <= stab_cnt + 1'b1;
      end
   end

   // Repeat FSM plus registered rise/fall/press pulses. Arming only happens
   // on the rising edge of level, so enabling repeat while already held
   // waits for the next press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         rpt_cnt <= '0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         press   <= 1'b0;
      end else begin
         rise  <= went_high;
         fall  <= went_low;
         press <= went_high | rpt_fire;
         if (went_low || !rpt_en) begin
            state   <= IDLE;
            rpt_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (went_high) begin
                     state   <= DELAY;
                     rpt_cnt <= '0;
                  end
               end
               DELAY: begin
                  if (rpt_cnt == DELAY_LAST) begin
                     state   <= REPEAT;
                     rpt_cnt <= '0;
                  end else begin
                     rpt_cnt <= rpt_cnt + 1'b1;
                  end
               end
               REPEAT: begin
                  if (rpt_cnt == RATE_LAST) begin
                     rpt_cnt <= '0;
                  end else begin
                     rpt_cnt <= rpt_cnt + 1'b1;
                  end
               end
               default: begin
                  state   <= IDLE;
                  rpt_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// N independent button channels: synchronise, debounce, edge-detect and
// auto-repeat. Channels share only clock and reset.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N             = 4,
   parameter int STABLE_CYCLES = 16,
   parameter int REPEAT_DELAY  = 64,
   parameter int REPEAT_RATE   = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] din,
   input  logic [N-1:0] rpt_en,
   output logic [N-1:0] level,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [N-1:0] press
);

   // One self-contained channel per input bit.
   for (genvar i = 0; i < N; i++) begin : g_chan
      btn_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_RATE   (REPEAT_RATE)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .din    (din[i]),
         .rpt_en (rpt_en[i]),
         .level  (level[i]),
         .rise   (rise[i]),
         .fall   (fall[i]),
         .press  (press[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (N=4, STABLE=4, DELAY=8, RATE=3).
module tb_button_conditioner;

   localparam int N = 4;
   localparam int S = 4;
   localparam int D = 8;
   localparam int R = 3;
   localparam int W = 4 * N;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] din;
   logic [N-1:0] rpt_en;
   logic [N-1:0] level;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] press;

   always #5 clk = ~clk;

   button_conditioner #(
      .N             (N),
      .STABLE_CYCLES (S),
      .REPEAT_DELAY  (D),
      .REPEAT_RATE   (R)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .din    (din),
      .rpt_en (rpt_en),
      .level  (level),
      .rise   (rise),
      .fall   (fall),
      .press  (press)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   // Reference model: sampled-input history and a window of disagreement
   // flags; repeat pulses derived from the age since the armed rising edge.
   logic [N-1:0] m_p1, m_p2, m_lvl, m_armed;
   logic [S-1:0] m_diff [N];
   int           m_age  [N];

   // Observation statistics, reset per scenario.
   int edge_no;
   int press_cnt [N];
   int rise_cnt  [N];
   int fall_cnt  [N];
   int hi_cnt    [N];
   int rise_edge [N];
   int fall_edge [N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_p1    = '0;
      m_p2    = '0;
      m_lvl   = '0;
      m_armed = '0;
      for (int i = 0; i < N; i++) begin
         m_diff[i] = '0;
         m_age[i]  = 0;
      end
   endtask

   // Advance the model by one rising edge; returns {level,rise,fall,press}.
   task automatic model_edge(output logic [W-1:0] v);
      logic [N-1:0] r, f, p;
      logic         sync_v;
      r = '0;
      f = '0;
      p = '0;
      if (!rst) begin
         model_reset();
         v = '0;
         return;
      end
      for (int i = 0; i < N; i++) begin
         sync_v    = m_p2[i];
         m_p2[i]   = m_p1[i];
         m_p1[i]   = din[i];
         m_diff[i] = {m_diff[i][S-2:0], (sync_v != m_lvl[i])};
         if (&m_diff[i]) begin
            m_lvl[i]  = ~m_lvl[i];
            m_diff[i] = '0;
            if (m_lvl[i]) r[i] = 1'b1;
            else          f[i] = 1'b1;
         end
         if (r[i]) begin
            m_armed[i] = rpt_en[i];
            m_age[i]   = 0;
         end else if (f[i] || !rpt_en[i]) begin
            m_armed[i] = 1'b0;
         end else if (m_armed[i]) begin
            m_age[i]++;
            if (m_age[i] >= D && ((m_age[i] - D) % R) == 0) p[i] = 1'b1;
         end
      end
      v = {m_lvl, r, f, r | p};
   endtask

   task automatic clear_stats();
      edge_no = 0;
      for (int i = 0; i < N; i++) begin
         press_cnt[i] = 0;
         rise_cnt[i]  = 0;
         fall_cnt[i]  = 0;
         hi_cnt[i]    = 0;
         rise_edge[i] = -1;
         fall_edge[i] = -1;
      end
   endtask

   // ---------------- driver / monitor ----------------
   // Each clock: model predicts at the edge, prediction queued, DUT sampled
   // 1 time unit later and compared against the popped prediction.
   task automatic step(input int n);
      logic [W-1:0] v, e;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge(v);
         exp_q.push_back(v);
         edge_no++;
         #1;
         e = exp_q.pop_front();
         check("sb_outputs", {level, rise, fall, press}, e);
         for (int i = 0; i < N; i++) begin
            if (press[i]) press_cnt[i]++;
            if (level[i]) hi_cnt[i]++;
            if (rise[i]) begin
               rise_cnt[i]++;
               rise_edge[i] = edge_no;
            end
            if (fall[i]) begin
               fall_cnt[i]++;
               fall_edge[i] = edge_no;
            end
         end
      end
   endtask

   // Hard bound on total simulation time.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst    = 1'b0;
      din    = '0;
      rpt_en = '0;
      model_reset();
      clear_stats();

      // Reset state
      step(3);
      check("reset_out", {level, rise, fall, press}, '0);
      rst = 1'b1;
      step(3);

      // Clean press on channel 0: rise on the 6th edge after the change
      clear_stats();
      din[0] = 1'b1;
      step(5);
      check("clean_level_early", level[0], 1'b0);
      step(1);
      check("clean_rise", rise[0], 1'b1);
      check("clean_level", level[0], 1'b1);
      step(1);
      check("clean_rise_one_cycle", rise[0], 1'b0);
      step(5);
      check("clean_rise_cnt", rise_cnt[0], 1);
      check("clean_fall_cnt", fall_cnt[0], 0);
      check("clean_press_cnt", press_cnt[0], 1);
      din[0] = 1'b0;
      clear_stats();
      step(8);
      check("clean_fall_edge", fall_edge[0], 6);

      // Glitch on channel 1: three clocks high is too short
      clear_stats();
      din[1] = 1'b1;
      step(3);
      din[1] = 1'b0;
      step(10);
      check("glitch_level", hi_cnt[1], 0);
      check("glitch_rise", rise_cnt[1], 0);
      check("glitch_press", press_cnt[1], 0);

      // Auto-repeat on channel 2: presses at edges 6,14,17,...,38
      clear_stats();
      rpt_en[2] = 1'b1;
      din[2]    = 1'b1;
      step(40);
      check("rpt_rise_edge", rise_edge[2], 6);
      check("rpt_press_cnt", press_cnt[2], 10);
      din[2] = 1'b0;
      clear_stats();
      step(6);
      check("rpt_fall_edge", fall_edge[2], 6);
      clear_stats();
      step(10);
      check("rpt_after_fall", press_cnt[2], 0);

      // Repeat disable during REPEAT, then re-enable while held
      clear_stats();
      din[2] = 1'b1;
      step(20);
      rpt_en[2] = 1'b0;
      clear_stats();
      step(15);
      check("dis_press", press_cnt[2], 0);
      check("dis_level", level[2], 1'b1);
      rpt_en[2] = 1'b1;
      clear_stats();
      step(20);
      check("reen_held_press", press_cnt[2], 0);
      din[2]    = 1'b0;
      rpt_en[2] = 1'b0;
      step(8);

      // Asynchronous reset during DELAY on channel 3
      clear_stats();
      rpt_en[3] = 1'b1;
      din[3]    = 1'b1;
      step(9);
      check("pre_reset_level", level[3], 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_out", {level, rise, fall, press}, '0);
      step(2);
      rst = 1'b1;
      clear_stats();
      step(12);
      check("post_reset_rise_cnt", rise_cnt[3], 1);
      check("post_reset_rise_edge", rise_edge[3], 6);
      din[3]    = 1'b0;
      rpt_en[3] = 1'b0;
      step(8);

      // All four channels pressed together
      clear_stats();
      din = '1;
      step(8);
      for (int i = 0; i < N; i++) begin
         check($sformatf("par_rise_edge_%0d", i), rise_edge[i], 6);
         check($sformatf("par_rise_cnt_%0d", i), rise_cnt[i], 1);
      end
      din = '0;
      clear_stats();
      step(8);
      for (int i = 0; i < N; i++) begin
         check($sformatf("par_fall_edge_%0d", i), fall_edge[i], 6);
      end

      // Random mix of holds, glitches, repeat enables and resets
      for (int it = 0; it < 300; it++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) == 0) din[i] = ~din[i];
            if ($urandom_range(0, 5) == 0) rpt_en[i] = ~rpt_en[i];
         end
         if ($urandom_range(0, 40) == 0) begin
            rst = 1'b0;
            step($urandom_range(1, 2));
            rst = 1'b1;
         end
         step($urandom_range(1, 14));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
